// File: rtl/reg_file_pkg.sv
// Shared core constants for the architectural register file.
package reg_file_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int ROB_W_DEF = 4;
  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] X0_IDX = '0;
  localparam int RD_PORTS  = 2;
endpackage

// File: rtl/reg_file.sv
// Architectural register file with per-register busy/ROB-tag rename state,
// commit write-back, same-cycle commit bypass on the query ports and flush.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_W = ROB_W_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    rename_config,
  input  logic [REG_IDX_W-1:0]    rename_rd,
  input  logic [ROB_W-1:0]        rename_rob,
  input  logic                    commit_reg_config,
  input  logic [REG_IDX_W-1:0]    commit_reg_id,
  input  logic [XLEN-1:0]         commit_reg_value,
  input  logic [ROB_W-1:0]        commit_reg_rob,
  input  logic [REG_IDX_W-1:0]    rs1_id,
  input  logic [REG_IDX_W-1:0]    rs2_id,
  output logic [XLEN-1:0]         rs1_value,
  output logic [XLEN-1:0]         rs2_value,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [ROB_W-1:0]        rs1_rob,
  output logic [ROB_W-1:0]        rs2_rob,
  output logic [REG_NUM*XLEN-1:0] reg_debugger
);

  logic [REG_NUM-1:0][XLEN-1:0]  val_q, val_d;
  logic [REG_NUM-1:0]            busy_q, busy_d;
  logic [REG_NUM-1:0][ROB_W-1:0] tag_q, tag_d;

  logic commit_en, rename_en;
  assign commit_en = commit_reg_config && (commit_reg_id != X0_IDX);
  assign rename_en = rename_config && !rollback && (rename_rd != X0_IDX);

  // Rename is applied after commit so it wins on a same-register collision.
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_en) begin
      val_d[commit_reg_id] = commit_reg_value;
      if (tag_q[commit_reg_id] == commit_reg_rob) begin
        busy_d[commit_reg_id] = 1'b0;
        tag_d[commit_reg_id]  = '0;
      end
    end
    if (rollback) begin
      busy_d = '0;
      tag_d  = '0;
    end else if (rename_en) begin
      busy_d[rename_rd] = 1'b1;
      tag_d[rename_rd]  = rename_rob;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else if (rdy) begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  // Query ports share one lookup; forced to zero for x0 and while in reset
  // so nothing uninitialised leaks out before the first reset edge.
  logic [RD_PORTS-1:0][REG_IDX_W-1:0] q_id;
  logic [RD_PORTS-1:0][XLEN-1:0]      q_val;
  logic [RD_PORTS-1:0]                q_busy;
  logic [RD_PORTS-1:0][ROB_W-1:0]     q_rob;

  assign q_id[0] = rs1_id;
  assign q_id[1] = rs2_id;

  always_comb begin
    q_val  = '0;
    q_busy = '0;
    q_rob  = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      q_val[p]  = val_q[q_id[p]];
      q_busy[p] = busy_q[q_id[p]];
      q_rob[p]  = tag_q[q_id[p]];
      if (commit_reg_config && (commit_reg_id == q_id[p]) &&
          busy_q[q_id[p]] && (tag_q[q_id[p]] == commit_reg_rob)) begin
        q_val[p]  = commit_reg_value;
        q_busy[p] = 1'b0;
        q_rob[p]  = '0;
      end
      if (!rst || (q_id[p] == X0_IDX)) begin
        q_val[p]  = '0;
        q_busy[p] = 1'b0;
        q_rob[p]  = '0;
      end
    end
  end

  assign rs1_value = q_val[0];
  assign rs2_value = q_val[1];
  assign rs1_busy  = q_busy[0];
  assign rs2_busy  = q_busy[1];
  assign rs1_rob   = q_rob[0];
  assign rs2_rob   = q_rob[1];

  assign reg_debugger = rst ? val_q : '0;

endmodule
